// File: rtl/tof_range_poller.sv
// tof_range_poller
// Sequencer and consumer for the I2C register-read block. Periodically kicks
// off a 2-byte read of the range result register, waits for done or failure,
// pops both bytes from the read block's FIFO, assembles a big-endian range and
// strobes it out. Failed transactions bump a saturating error counter.
//
// Build option:
//   TOF_RANGE_FILTER_EN  when defined, each published range is the mean of the
//                        last four good samples (history starts zeroed).
module tof_range_poller #(
  parameter int unsigned POLL_CYCLES     = 810000,
  parameter int unsigned WATCHDOG_CYCLES = 270000,
  parameter logic [6:0]  DEV_ADDR        = 7'h29,
  parameter logic [7:0]  RANGE_REG       = 8'h1E
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        rd_start,
  output logic [6:0]  rd_dev_address,
  output logic [7:0]  rd_reg_address,
  output logic [3:0]  rd_byte_width,
  input  logic        rd_done,
  input  logic        rd_message_failure,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  input  logic        fifo_read_valid,
  output logic        fifo_read_en,
  output logic [15:0] range_mm,
  output logic        range_valid,
  output logic [7:0]  err_count,
  output logic        busy
);

  localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int WD_W   = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [POLL_W-1:0] POLL_RELOAD = POLL_W'(POLL_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_RELOAD   = WD_W'(WATCHDOG_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    START,
    WAIT_DONE,
    POP_HI,
    WAIT_HI,
    POP_LO,
    WAIT_LO,
    PUBLISH,
    ERROR
  } state_t;

  state_t            state;
  logic [POLL_W-1:0] poll_cnt;
  logic [WD_W-1:0]   wd_cnt;
  logic [1:0]        valid_timer;
  logic [7:0]        hi_byte;
  logic              rd_done_q;
  logic              rd_fail_q;
  logic              done_rise;
  logic              fail_rise;
  logic              publish_go;
  logic [15:0]       sample_new;
  logic [15:0]       publish_value;

  // Transaction parameters never change; the read block samples them on start.
  assign rd_dev_address = DEV_ADDR;
  assign rd_reg_address = RANGE_REG;
  assign rd_byte_width  = 4'd2;

  // Edge-detect the read block's level-type status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_done_q <= 1'b0;
      rd_fail_q <= 1'b0;
    end else begin
      rd_done_q <= rd_done;
      rd_fail_q <= rd_message_failure;
    end
  end

  // Rising edges of done/failure plus the publish condition and raw sample.
  always_comb begin
    // NOTE: every always_comb output is given a value on every path (here
    // unconditionally) so no latch can be inferred.
    done_rise  = rd_done & ~rd_done_q;
    fail_rise  = rd_message_failure & ~rd_fail_q;
    publish_go = (state == WAIT_LO) && fifo_read_valid;
    sample_new = {hi_byte, fifo_data};
  end

`ifdef TOF_RANGE_FILTER_EN
  logic [15:0] hist [4];
  logic [17:0] acc;
  logic [17:0] acc_next;

  // Running sum of the four most recent samples: add newest, drop oldest.
  always_comb begin
    acc_next      = acc + 18'(sample_new) - 18'(hist[3]);
    publish_value = acc_next[17:2];
  end

  // History shift register and accumulator, advanced only on good samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the history is explicitly cleared on reset because the average
      // deliberately folds these zeros in until four samples have arrived.
      for (int i = 0; i < 4; i++) hist[i] <= 16'd0;
      acc <= 18'd0;
    end else if (publish_go) begin
      hist[0] <= sample_new;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      hist[3] <= hist[2];
      acc     <= acc_next;
    end
  end
`else
  // Unfiltered build: publish the raw assembled sample.
  always_comb begin
    publish_value = sample_new;
  end
`endif

  // Main sequencer: poll timing, transaction tracking, FIFO handshake, outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rd_start     <= 1'b0;
      fifo_read_en <= 1'b0;
      range_mm     <= 16'd0;
      range_valid  <= 1'b0;
      err_count    <= 8'd0;
      busy         <= 1'b0;
      poll_cnt     <= '0;
      wd_cnt       <= '0;
      valid_timer  <= 2'd0;
      hi_byte      <= 8'd0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // sees the pre-edge values; later assignments below override defaults.
      rd_start     <= 1'b0;
      fifo_read_en <= 1'b0;
      range_valid  <= 1'b0;

      // Poll interval counts down to zero and waits there for IDLE.
      if (poll_cnt != '0) poll_cnt <= poll_cnt - 1'b1;

      case (state)
        IDLE: begin
          if (enable && poll_cnt == '0) begin
            state    <= START;
            rd_start <= 1'b1;
            busy     <= 1'b1;
            poll_cnt <= POLL_RELOAD;
          end
        end

        START: begin
          wd_cnt <= WD_RELOAD;
          state  <= WAIT_DONE;
        end

        WAIT_DONE: begin
          // Failure wins over a coincident done.
          if (fail_rise) begin
            state <= ERROR;
          end else if (done_rise) begin
            state <= POP_HI;
          end else if (wd_cnt == '0) begin
            state <= ERROR;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end

        POP_HI: begin
          if (!fifo_empty) begin
            fifo_read_en <= 1'b1;
            valid_timer  <= 2'd3;
            state        <= WAIT_HI;
          end else begin
            state <= ERROR;
          end
        end

        WAIT_HI: begin
          if (fifo_read_valid) begin
            hi_byte <= fifo_data;
            state   <= POP_LO;
          end else if (valid_timer == 2'd0) begin
            state <= ERROR;
          end else begin
            valid_timer <= valid_timer - 2'd1;
          end
        end

        POP_LO: begin
          if (!fifo_empty) begin
            fifo_read_en <= 1'b1;
            valid_timer  <= 2'd3;
            state        <= WAIT_LO;
          end else begin
            state <= ERROR;
          end
        end

        WAIT_LO: begin
          // Low byte arrives: range and strobe are registered together so
          // range_valid is high during PUBLISH alongside the new range_mm.
          if (publish_go) begin
            range_mm    <= publish_value;
            range_valid <= 1'b1;
            state       <= PUBLISH;
          end else if (valid_timer == 2'd0) begin
            state <= ERROR;
          end else begin
            valid_timer <= valid_timer - 2'd1;
          end
        end

        PUBLISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        ERROR: begin
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tof_range_poller.sv
// tb_tof_range_poller
// Directed bench: a small read-block/FIFO model answers each poll; expected
// ranges are queued by the stimulus and checked by an independent monitor.
module tb_tof_range_poller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        rd_done = 1'b0;
  logic        rd_message_failure = 1'b0;
  logic        rd_start;
  logic [6:0]  rd_dev_address;
  logic [7:0]  rd_reg_address;
  logic [3:0]  rd_byte_width;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic        fifo_read_valid;
  logic        fifo_read_en;
  logic [15:0] range_mm;
  logic        range_valid;
  logic [7:0]  err_count;
  logic        busy;

  tof_range_poller #(
    .POLL_CYCLES     (100),
    .WATCHDOG_CYCLES (50),
    .DEV_ADDR        (7'h29),
    .RANGE_REG       (8'h1E)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .rd_start           (rd_start),
    .rd_dev_address     (rd_dev_address),
    .rd_reg_address     (rd_reg_address),
    .rd_byte_width      (rd_byte_width),
    .rd_done            (rd_done),
    .rd_message_failure (rd_message_failure),
    .fifo_data          (fifo_data),
    .fifo_empty         (fifo_empty),
    .fifo_read_valid    (fifo_read_valid),
    .fifo_read_en       (fifo_read_en),
    .range_mm           (range_mm),
    .range_valid        (range_valid),
    .err_count          (err_count),
    .busy               (busy)
  );

  initial forever #5 clk = ~clk;

  // Expected published values (hand-computed).
`ifdef TOF_RANGE_FILTER_EN
  localparam logic [15:0] EXP_FIRST = 16'd125;   // (500+0+0+0)/4
  localparam logic [15:0] EXP_A0 = 16'd100;      // 400/4
  localparam logic [15:0] EXP_A1 = 16'd200;
  localparam logic [15:0] EXP_A2 = 16'd300;
  localparam logic [15:0] EXP_A3 = 16'd400;
`else
  localparam logic [15:0] EXP_FIRST = 16'h01F4;
  localparam logic [15:0] EXP_A0 = 16'd400;
  localparam logic [15:0] EXP_A1 = 16'd400;
  localparam logic [15:0] EXP_A2 = 16'd400;
  localparam logic [15:0] EXP_A3 = 16'd400;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle counter, advanced on each rising edge.
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Read-block FIFO model: cleared on start, one-cycle read latency.
  logic [7:0] fifo_bytes [2];
  int fifo_loaded = 0;
  int fifo_ptr = 0;
  int en_cnt = 0;
  int underflows = 0;
  assign fifo_empty = (fifo_ptr >= fifo_loaded);

  initial begin
    fifo_data = 8'h00;
    fifo_read_valid = 1'b0;
    forever begin
      @(posedge clk);
      fifo_read_valid <= 1'b0;
      if (rd_start) begin
        fifo_ptr <= 0;
        en_cnt   <= 0;
      end else if (fifo_read_en) begin
        en_cnt <= en_cnt + 1;
        if (fifo_empty) begin
          underflows <= underflows + 1;
        end else begin
          fifo_data       <= fifo_bytes[fifo_ptr];
          fifo_read_valid <= 1'b1;
          fifo_ptr        <= fifo_ptr + 1;
        end
      end
    end
  end

  // Scoreboard monitor: records starts, checks each range_valid strobe.
  logic [15:0] sb [$];
  int start_cnt = 0;
  int start_cyc = 0;
  int valid_cyc = 0;
  logic prev_rv = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rd_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (!reset && range_valid) begin
      logic [15:0] exp_range;
      valid_cyc = cyc;
      check("range_valid_single_cycle", {31'd0, prev_rv}, 32'd0);
      check("range_valid_expected", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        exp_range = sb.pop_front();
        check("range_mm", {16'd0, range_mm}, {16'd0, exp_range});
      end
    end
    prev_rv = range_valid;
  end

  // Global time bound.
  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  int done_cyc = 0;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_start();
    int n0 = start_cnt;
    int k = 0;
    while (start_cnt == n0 && k < 1000) begin
      tick();
      k++;
    end
    check("start_seen", {31'd0, start_cnt != n0}, 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 1000) begin
      tick();
      k++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic respond_good(input logic [7:0] hi, input logic [7:0] lo, input logic [15:0] exp_range);
    fifo_bytes[0] = hi;
    fifo_bytes[1] = lo;
    fifo_loaded = 2;
    sb.push_back(exp_range);
    done_cyc = cyc;
    rd_done = 1'b1;
    tick(2);
    rd_done = 1'b0;
    wait_idle();
  endtask

  task automatic respond_fail(input logic with_done);
    fifo_loaded = 0;
    rd_message_failure = 1'b1;
    rd_done = with_done;
    tick(2);
    rd_message_failure = 1'b0;
    rd_done = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_start"}, {31'd0, rd_start}, 32'd0);
    check({tag, "_fifo_read_en"}, {31'd0, fifo_read_en}, 32'd0);
    check({tag, "_range_mm"}, {16'd0, range_mm}, 32'd0);
    check({tag, "_range_valid"}, {31'd0, range_valid}, 32'd0);
    check({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int s1;
    int rel;
    // Reset with polling already enabled.
    enable = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    check("dev_address", {25'd0, rd_dev_address}, 32'h29);
    check("reg_address", {24'd0, rd_reg_address}, 32'h1E);
    check("byte_width", {28'd0, rd_byte_width}, 32'd2);
    reset = 1'b0;
    rel = cyc;

    // Poll and publish.
    wait_start();
    check("first_start_latency", start_cyc - rel, 32'd1);
    s1 = start_cyc;
    respond_good(8'h01, 8'hF4, EXP_FIRST);
    check("done_to_valid_latency", valid_cyc - done_cyc, 32'd7);
    wait_start();
    check("poll_interval", start_cyc - s1, 32'd100);

    // Transaction failure.
    respond_fail(1'b0);
    check("err_after_failure", {24'd0, err_count}, 32'd1);
    check("range_kept_after_failure", {16'd0, range_mm}, {16'd0, EXP_FIRST});

    // Watchdog: no response at all.
    wait_start();
    s1 = start_cyc;
    fifo_loaded = 0;
    wait_idle();
    check("watchdog_idle_cycle", cyc - s1, 32'd52);
    check("err_after_watchdog", {24'd0, err_count}, 32'd2);
    wait_start();
    check("poll_after_watchdog", start_cyc - s1, 32'd100);

    // Empty FIFO on the low byte.
    fifo_bytes[0] = 8'hAB;
    fifo_loaded = 1;
    rd_done = 1'b1;
    tick(2);
    rd_done = 1'b0;
    wait_idle();
    check("err_after_empty", {24'd0, err_count}, 32'd3);
    check("single_pop_on_empty", en_cnt, 32'd1);
    check("range_kept_after_empty", {16'd0, range_mm}, {16'd0, EXP_FIRST});

    // Done and failure rise together.
    wait_start();
    respond_fail(1'b1);
    check("err_after_coincidence", {24'd0, err_count}, 32'd4);

    // Reset while waiting for the low byte.
    wait_start();
    fifo_bytes[0] = 8'h12;
    fifo_bytes[1] = 8'h34;
    fifo_loaded = 2;
    rd_done = 1'b1;
    tick(2);
    rd_done = 1'b0;
    tick(3);
    check("in_wait_lo_busy", {31'd0, busy}, 32'd1);
    check("in_wait_lo_pop", {31'd0, fifo_read_en}, 32'd1);
    reset = 1'b1;
    tick();
    check_reset_outputs("midreset");
    reset = 1'b0;

    // Four identical samples of 400 mm.
    wait_start();
    respond_good(8'h01, 8'h90, EXP_A0);
    wait_start();
    respond_good(8'h01, 8'h90, EXP_A1);
    wait_start();
    respond_good(8'h01, 8'h90, EXP_A2);
    wait_start();
    respond_good(8'h01, 8'h90, EXP_A3);

    // Error counter saturation.
    for (int i = 0; i < 256; i++) begin
      wait_start();
      respond_fail(1'b0);
      if (i == 9) check("err_count_10", {24'd0, err_count}, 32'd10);
      if (i == 254) check("err_count_255", {24'd0, err_count}, 32'hFF);
    end
    check("err_count_saturated", {24'd0, err_count}, 32'hFF);

    tick(5);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("no_fifo_underflow", underflows, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
